maria_dma_sched: RTL and testbench

- Parametrised Maria DMA timing scheduler.
- Generates CPU/TIA/POKEY clocks, HALT/READY/DLI to the 6502, and ZP/DP DMA start, kill and lineram-swap strobes to dma_ctrl and line_ram.
- Generalises the Maria timing controller with run-time NTSC/PAL line count and start-of-line delay counted in CPU ticks.
- Adds an active DP DMA kill column, a single parametrised cooldown state, and configurable clock dividers and DLI pulse length.

---
 rtl/maria_pkg.sv | 29 ++
 rtl/maria_clkgen.sv | 62 ++++++
 rtl/maria_dma_sched.sv | 205 ++++++++++++++++++++
 tb/tb_maria_dma_sched.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maria_pkg.sv
// Shared state encoding and default timing constants for the Maria DMA scheduler.
package maria_pkg;

   typedef enum logic [3:0] {
      VWAIT      = 4'd0,
      HWAIT      = 4'd1,
      ZP_STARTUP = 4'd2,
      ZP_DMA     = 4'd3,
      SOL        = 4'd4,
      DP_STARTUP = 4'd5,
      DP_DMA     = 4'd6,
      COOLDOWN   = 4'd7
   } sched_state_e;

   localparam int DEF_COL_W         = 10;
   localparam int DEF_FAST_DIV      = 4;
   localparam int DEF_SLOW_DIV      = 6;
   localparam int DEF_STARTUP_CYC   = 9;
   localparam int DEF_SOL_CPU_TICKS = 7;
   localparam int DEF_COOLDOWN_CYC  = 1;
   localparam int DEF_KILL_COL      = 439;
   localparam int DEF_ZP_ROW        = 15;
   localparam int DEF_ZP_COL        = 393;
   localparam int DEF_VBLANK_ROWS   = 15;
   localparam int DEF_NTSC_LINES    = 243;
   localparam int DEF_PAL_LINES     = 293;
   localparam int DEF_DLI_LEN       = 6;

endpackage

// File: rtl/maria_clkgen.sv
// CPU/TIA/POKEY clock dividers plus the CPU-edge strobes used by the scheduler FSM.
module maria_clkgen #(
   parameter int FAST_DIV = 4,
   parameter int SLOW_DIV = 6
) (
   input  logic sysclk,
   input  logic reset,
   input  logic sel_slow_clock,
   output logic pclk_0,
   output logic tia_clk,
   output logic pokey_clock,
   output logic cpu_rise,
   output logic phase_ok
);

   localparam int FAST_HALF = FAST_DIV / 2;
   localparam int SLOW_HALF = SLOW_DIV / 2;

   logic [7:0] fast_ctr, slow_ctr;
   logic       fast_clk, slow_clk;
   logic       half_last;

   always_ff @(posedge sysclk) begin
      if (reset) begin
         tia_clk  <= 1'b0;
         fast_clk <= 1'b1;
         slow_clk <= 1'b1;
         fast_ctr <= '0;
         slow_ctr <= '0;
      end else begin
         tia_clk <= ~tia_clk;
         // The idle divider is parked high at count 0 so a switch starts a clean high half
         if (!sel_slow_clock) begin
            slow_clk <= 1'b1;
            slow_ctr <= '0;
            if (fast_ctr == 8'(FAST_HALF - 1)) begin
               fast_clk <= ~fast_clk;
               fast_ctr <= '0;
            end else begin
               fast_ctr <= fast_ctr + 8'd1;
            end
         end else begin
            fast_clk <= 1'b1;
            fast_ctr <= '0;
            if (slow_ctr == 8'(SLOW_HALF - 1)) begin
               slow_clk <= ~slow_clk;
               slow_ctr <= '0;
            end else begin
               slow_ctr <= slow_ctr + 8'd1;
            end
         end
      end
   end

   assign pclk_0      = sel_slow_clock ? slow_clk : fast_clk;
   assign pokey_clock = ~fast_clk;
   assign half_last   = sel_slow_clock ? (slow_ctr == 8'(SLOW_HALF - 1))
                                       : (fast_ctr == 8'(FAST_HALF - 1));
   assign cpu_rise    = ~pclk_0 & half_last;
   assign phase_ok    = pclk_0 & ~half_last;

endmodule

// File: rtl/maria_dma_sched.sv
// Maria DMA timing scheduler: 6502 HALT/RDY/NMI control and ZP/DP DMA sequencing per scanline.
module maria_dma_sched
   import maria_pkg::*;
#(
   parameter int COL_W         = DEF_COL_W,
   parameter int FAST_DIV      = DEF_FAST_DIV,
   parameter int SLOW_DIV      = DEF_SLOW_DIV,
   parameter int STARTUP_CYC   = DEF_STARTUP_CYC,
   parameter int SOL_CPU_TICKS = DEF_SOL_CPU_TICKS,
   parameter int COOLDOWN_CYC  = DEF_COOLDOWN_CYC,
   parameter bit KILL_EN       = 1'b1,
   parameter int KILL_COL      = DEF_KILL_COL,
   parameter int ZP_ROW        = DEF_ZP_ROW,
   parameter int ZP_COL        = DEF_ZP_COL,
   parameter int VBLANK_ROWS   = DEF_VBLANK_ROWS,
   parameter int NTSC_LINES    = DEF_NTSC_LINES,
   parameter int PAL_LINES     = DEF_PAL_LINES,
   parameter int DLI_LEN       = DEF_DLI_LEN
) (
   input  logic             sysclk,
   input  logic             reset,
   input  logic             enable,
   input  logic             pal_mode,
   input  logic             sel_slow_clock,
   input  logic             hblank,
   input  logic [COL_W-1:0] vga_row,
   input  logic [COL_W-1:0] vga_col,
   input  logic             zp_written,
   input  logic             deassert_ready,
   input  logic             zp_dma_done,
   input  logic             dp_dma_done,
   input  logic             dp_dma_done_dli,
   output logic             pclk_0,
   output logic             tia_clk,
   output logic             pokey_clock,
   output logic             halt_b,
   output logic             int_b,
   output logic             ready,
   output logic             zp_dma_start,
   output logic             dp_dma_start,
   output logic             dp_dma_kill,
   output logic             last_line,
   output logic             lram_swap,
   output logic [3:0]       state_o
);

   sched_state_e     state, ret, ret_line;
   logic             cpu_rise, phase_ok;
   logic             hblank_d, hblank_rise, en_seen, pal_lat;
   logic             raise_dli, dli_next;
   logic [7:0]       ctr, tick, dli_ctr;
   logic [COL_W-1:0] last_row;

   maria_clkgen #(.FAST_DIV(FAST_DIV), .SLOW_DIV(SLOW_DIV)) u_clkgen (
      .sysclk         (sysclk),
      .reset          (reset),
      .sel_slow_clock (sel_slow_clock),
      .pclk_0         (pclk_0),
      .tia_clk        (tia_clk),
      .pokey_clock    (pokey_clock),
      .cpu_rise       (cpu_rise),
      .phase_ok       (phase_ok)
   );

   assign hblank_rise = hblank & ~hblank_d;
   assign last_row    = pal_lat ? COL_W'(VBLANK_ROWS + PAL_LINES - 1)
                                : COL_W'(VBLANK_ROWS + NTSC_LINES - 1);
   assign last_line   = (vga_row == last_row);
   assign ret_line    = last_line ? VWAIT : HWAIT;
   assign lram_swap   = hblank_rise & en_seen;
   assign state_o     = state;

   always_ff @(posedge sysclk) begin
      if (reset) begin
         hblank_d <= 1'b0;
         ready    <= 1'b1;
         en_seen  <= 1'b0;
      end else begin
         hblank_d <= hblank;
         if (deassert_ready)   ready <= 1'b0;
         else if (hblank_rise) ready <= 1'b1;
         if (hblank_rise)      en_seen <= 1'b0;
         else if (enable)      en_seen <= 1'b1;
      end
   end

   always_ff @(posedge sysclk) begin
      if (reset) begin
         state        <= VWAIT;
         ret          <= VWAIT;
         ctr          <= '0;
         tick         <= '0;
         halt_b       <= 1'b1;
         raise_dli    <= 1'b0;
         dli_next     <= 1'b0;
         pal_lat      <= 1'b0;
         zp_dma_start <= 1'b0;
         dp_dma_start <= 1'b0;
         dp_dma_kill  <= 1'b0;
      end else begin
         zp_dma_start <= 1'b0;
         dp_dma_start <= 1'b0;
         dp_dma_kill  <= 1'b0;
         dli_next     <= 1'b0;
         case (state)
            VWAIT: begin
               pal_lat <= pal_mode;
               if (enable && zp_written && vga_row == COL_W'(ZP_ROW) && vga_col == COL_W'(ZP_COL)) begin
                  halt_b <= 1'b0;
                  ctr    <= 8'd1;
                  state  <= ZP_STARTUP;
               end
            end
            ZP_STARTUP: begin
               ctr <= ctr + 8'd1;
               if (ctr == 8'(STARTUP_CYC - 1)) begin
                  zp_dma_start <= 1'b1;
                  state        <= ZP_DMA;
               end
            end
            ZP_DMA: begin
               if (zp_dma_done) begin
                  raise_dli <= dp_dma_done_dli;
                  ret       <= HWAIT;
                  ctr       <= 8'd1;
                  state     <= COOLDOWN;
               end
            end
            HWAIT: begin
               if (hblank_rise && enable) begin
                  halt_b <= 1'b1;
                  tick   <= '0;
                  state  <= SOL;
               end else if (last_line) begin
                  state <= VWAIT;
               end
            end
            SOL: begin
               if (!enable) begin
                  ret   <= ret_line;
                  ctr   <= 8'd1;
                  state <= COOLDOWN;
               end else if (cpu_rise) begin
                  tick <= tick + 8'd1;
                  if (tick == 8'(SOL_CPU_TICKS - 1)) begin
                     halt_b <= 1'b0;
                     ctr    <= 8'd1;
                     state  <= DP_STARTUP;
                  end
               end
            end
            DP_STARTUP: begin
               ctr <= ctr + 8'd1;
               if (ctr == 8'(STARTUP_CYC - 1)) begin
                  dp_dma_start <= 1'b1;
                  raise_dli    <= 1'b0;
                  state        <= DP_DMA;
               end
            end
            DP_DMA: begin
               // A completion in the kill column is honoured as a normal finish
               if (dp_dma_done) begin
                  raise_dli <= dp_dma_done_dli;
                  ret       <= ret_line;
                  ctr       <= 8'd1;
                  state     <= COOLDOWN;
               end else if (KILL_EN && vga_col == COL_W'(KILL_COL)) begin
                  dp_dma_kill <= 1'b1;
                  raise_dli   <= 1'b0;
                  ret         <= ret_line;
                  ctr         <= 8'd1;
                  state       <= COOLDOWN;
               end
            end
            COOLDOWN: begin
               if (ctr < 8'(COOLDOWN_CYC)) begin
                  ctr <= ctr + 8'd1;
               end else if (phase_ok) begin
                  halt_b    <= 1'b1;
                  dli_next  <= raise_dli;
                  raise_dli <= 1'b0;
                  state     <= ret;
               end
            end
            default: state <= VWAIT;
         endcase
      end
   end

   // NMI pulse: a new DLI restarts the low window
   always_ff @(posedge sysclk) begin
      if (reset) begin
         int_b   <= 1'b1;
         dli_ctr <= '0;
      end else if (dli_next) begin
         int_b   <= 1'b0;
         dli_ctr <= 8'(DLI_LEN - 1);
      end else if (dli_ctr != 8'd0) begin
         dli_ctr <= dli_ctr - 8'd1;
      end else begin
         int_b <= 1'b1;
      end
   end

endmodule

// File: tb/tb_maria_dma_sched.sv
// Scoreboard bench for maria_dma_sched: stimulus queues expected output events, a monitor matches them.
module tb_maria_dma_sched;

   logic       sysclk = 1'b0;
   logic       reset, enable, pal_mode, sel_slow_clock, hblank;
   logic [9:0] vga_row, vga_col;
   logic       zp_written, deassert_ready, zp_dma_done, dp_dma_done, dp_dma_done_dli;
   logic       pclk_0, tia_clk, pokey_clock, halt_b, int_b, ready;
   logic       zp_dma_start, dp_dma_start, dp_dma_kill, last_line, lram_swap;
   logic [3:0] state_o;

   typedef enum int {EV_HALT_FALL, EV_HALT_RISE, EV_ZP, EV_DP, EV_KILL,
                     EV_INT_FALL, EV_INT_RISE, EV_SWAP} ev_e;
   typedef struct { ev_e kind; int at; } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;
   int   ref_c = 0;
   logic prev_halt = 1'b1;
   logic prev_int  = 1'b1;

   maria_dma_sched dut (
      .sysclk(sysclk), .reset(reset), .enable(enable), .pal_mode(pal_mode),
      .sel_slow_clock(sel_slow_clock), .hblank(hblank), .vga_row(vga_row),
      .vga_col(vga_col), .zp_written(zp_written), .deassert_ready(deassert_ready),
      .zp_dma_done(zp_dma_done), .dp_dma_done(dp_dma_done),
      .dp_dma_done_dli(dp_dma_done_dli), .pclk_0(pclk_0), .tia_clk(tia_clk),
      .pokey_clock(pokey_clock), .halt_b(halt_b), .int_b(int_b), .ready(ready),
      .zp_dma_start(zp_dma_start), .dp_dma_start(dp_dma_start),
      .dp_dma_kill(dp_dma_kill), .last_line(last_line), .lram_swap(lram_swap),
      .state_o(state_o)
   );

   always #5 sysclk = ~sysclk;
   always @(posedge sysclk) cyc <= cyc + 1;

   task automatic expect_ev(input ev_e k, input int at);
      exp_t e;
      e.kind = k;
      e.at   = at;
      sb.push_back(e);
   endtask

   task automatic observe(input ev_e k);
      int idx;
      idx = -1;
      for (int i = 0; i < sb.size(); i++)
         if (idx < 0 && sb[i].kind == k) idx = i;
      tests++;
      if (idx < 0) begin
         fails++;
         $display("FAIL event %s: seen at cycle %0d, none required", k.name(), cyc);
      end else begin
         if (sb[idx].at != cyc) begin
            fails++;
            $display("FAIL event %s: seen at cycle %0d, required at cycle %0d", k.name(), cyc, sb[idx].at);
         end
         sb.delete(idx);
      end
   endtask

   always @(negedge sysclk) begin
      if (prev_halt && !halt_b) observe(EV_HALT_FALL);
      if (!prev_halt && halt_b) observe(EV_HALT_RISE);
      if (zp_dma_start)         observe(EV_ZP);
      if (dp_dma_start)         observe(EV_DP);
      if (dp_dma_kill)          observe(EV_KILL);
      if (prev_int && !int_b)   observe(EV_INT_FALL);
      if (!prev_int && int_b)   observe(EV_INT_RISE);
      if (lram_swap)            observe(EV_SWAP);
      prev_halt = halt_b;
      prev_int  = int_b;
   end

   task automatic chk(input string nm, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge sysclk);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) step(1);
   endtask

   // First edge >= c at a given position in the 4-sysclk fast CPU clock period.
   // off 0: edge where pclk_0 rises; off 1: edge ending the first high sysclk.
   function automatic int align(input int c, input int off);
      int e;
      e = c;
      while ((((e - ref_c) % 4) + 4) % 4 != off) e++;
      return e;
   endfunction

   task automatic zp_path();
      int p, d, r;
      p = cyc;
      vga_row = 10'd15;
      vga_col = 10'd393;
      expect_ev(EV_HALT_FALL, p + 1);
      expect_ev(EV_ZP, p + 9);
      step(1);
      vga_col = 10'd0;
      wait_until(p + 12);
      d = cyc;
      zp_dma_done = 1'b1;
      r = align(d + 2, 1);
      expect_ev(EV_HALT_RISE, r);
      step(1);
      zp_dma_done = 1'b0;
      wait_until(r + 2);
      chk("state_after_zp", int'(state_o), 1);
   endtask

   task automatic dp_line();
      int h, e7;
      h = cyc;
      hblank = 1'b1;
      expect_ev(EV_SWAP, h);
      e7 = align(h + 2, 0) + 24;
      expect_ev(EV_HALT_FALL, e7);
      expect_ev(EV_DP, e7 + 8);
      step(3);
      hblank = 1'b0;
      wait_until(e7 + 9);
   endtask

   task automatic dp_finish(input logic kill_col, input logic with_dli);
      int k, e;
      k = cyc;
      vga_col = kill_col ? 10'd439 : 10'd200;
      dp_dma_done = 1'b1;
      dp_dma_done_dli = with_dli;
      e = align(k + 2, 1);
      expect_ev(EV_HALT_RISE, e);
      if (with_dli) begin
         expect_ev(EV_INT_FALL, e + 1);
         expect_ev(EV_INT_RISE, e + 7);
      end
      step(1);
      dp_dma_done = 1'b0;
      dp_dma_done_dli = 1'b0;
      vga_col = 10'd0;
      wait_until(e + 2);
      chk("state_after_dp", int'(state_o), last_line ? 0 : 1);
      wait_until(e + 9);
   endtask

   initial begin
      int k, e, h, x;
      reset = 1'b1; enable = 1'b0; pal_mode = 1'b0; sel_slow_clock = 1'b0;
      hblank = 1'b0; vga_row = '0; vga_col = '0; zp_written = 1'b0;
      deassert_ready = 1'b0; zp_dma_done = 1'b0; dp_dma_done = 1'b0;
      dp_dma_done_dli = 1'b0;
      step(3);
      reset = 1'b0;
      ref_c = cyc;
      chk("rst_halt_b", int'(halt_b), 1);
      chk("rst_int_b", int'(int_b), 1);
      chk("rst_ready", int'(ready), 1);
      chk("rst_strobes", int'({zp_dma_start, dp_dma_start, dp_dma_kill, lram_swap}), 0);
      chk("rst_state", int'(state_o), 0);

      // fast: period 4 high first; tia period 2
      for (int i = 0; i < 8; i++) begin
         chk("fast_pclk", int'(pclk_0), (i % 4) < 2 ? 1 : 0);
         chk("tia_clk", int'(tia_clk), i % 2);
         chk("pokey_clock", int'(pokey_clock), (i % 4) < 2 ? 0 : 1);
         step(1);
      end
      sel_slow_clock = 1'b1;
      #1;
      for (int i = 0; i < 12; i++) begin
         chk("slow_pclk", int'(pclk_0), (i % 6) < 3 ? 1 : 0);
         step(1);
      end
      sel_slow_clock = 1'b0;
      ref_c = cyc;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk("fast_again_pclk", int'(pclk_0), (i % 4) < 2 ? 1 : 0);
         step(1);
      end

      vga_row = 10'd257; #1 chk("ntsc_last_257", int'(last_line), 1);
      vga_row = 10'd256; #1 chk("ntsc_last_256", int'(last_line), 0);
      vga_row = 10'd307; #1 chk("ntsc_last_307", int'(last_line), 0);

      enable = 1'b1;
      zp_written = 1'b1;
      zp_path();

      vga_row = 10'd100;
      dp_line();
      dp_finish(1'b0, 1'b1);

      // kill column reached with no completion
      dp_line();
      step(2);
      k = cyc;
      vga_col = 10'd439;
      dp_dma_done_dli = 1'b1;
      e = align(k + 2, 1);
      expect_ev(EV_KILL, k + 1);
      expect_ev(EV_HALT_RISE, e);
      step(3);
      vga_col = 10'd0;
      dp_dma_done_dli = 1'b0;
      wait_until(e + 3);
      chk("state_after_kill", int'(state_o), 1);

      // completion in the kill column on the last line: no kill, DLI, back to VWAIT
      dp_line();
      vga_row = 10'd257;
      dp_finish(1'b1, 1'b1);
      chk("state_vwait", int'(state_o), 0);

      pal_mode = 1'b1;
      step(1);
      vga_row = 10'd307; #1 chk("pal_last_307", int'(last_line), 1);
      vga_row = 10'd257; #1 chk("pal_last_257", int'(last_line), 0);

      deassert_ready = 1'b1;
      step(1);
      deassert_ready = 1'b0;
      #1 chk("ready_cleared", int'(ready), 0);
      h = cyc;
      hblank = 1'b1;
      expect_ev(EV_SWAP, h);
      step(1);
      hblank = 1'b0;
      #1 chk("ready_set", int'(ready), 1);
      step(2);
      h = cyc;
      hblank = 1'b1;
      deassert_ready = 1'b1;
      expect_ev(EV_SWAP, h);
      step(1);
      hblank = 1'b0;
      deassert_ready = 1'b0;
      #1 chk("ready_clear_wins", int'(ready), 0);
      step(2);

      zp_path();
      vga_row = 10'd100;
      dp_line();
      step(1);
      x = cyc;
      reset = 1'b1;
      expect_ev(EV_HALT_RISE, x + 1);
      step(1);
      reset = 1'b0;
      ref_c = cyc;
      chk("mid_rst_halt_b", int'(halt_b), 1);
      chk("mid_rst_state", int'(state_o), 0);
      chk("mid_rst_strobes", int'({zp_dma_start, dp_dma_start, dp_dma_kill}), 0);
      chk("mid_rst_int_b", int'(int_b), 1);
      step(12);

      for (int i = 0; i < 40 && sb.size() > 0; i++) step(1);
      while (sb.size() > 0) begin
         tests++;
         fails++;
         $display("FAIL event %s: not seen, required at cycle %0d", sb[0].kind.name(), sb[0].at);
         sb.delete(0);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: run did not complete, %0d checks done", tests);
      $fatal(1, "timeout");
   end

endmodule
